// File: rtl/rr_ring_arbiter_if.sv
// rr_ring_arbiter_if: request/grant bundle between requesters and the ring arbiter
interface rr_ring_arbiter_if #(
    parameter int NREQ    = 4,
    parameter int QUANTUM = 8,
    parameter int IDW     = $clog2(NREQ),
    parameter int QW      = (QUANTUM > 1) ? $clog2(QUANTUM) : 1
);
    logic [NREQ-1:0] req;
    logic [NREQ-1:0] grant;
    logic            grant_valid;
    logic [IDW-1:0]  grant_id;
    logic [NREQ-1:0] ptr;
    logic [QW-1:0]   slice_cnt;

    modport master (output req, input grant, grant_valid, grant_id, ptr, slice_cnt);
    modport slave  (input req, output grant, grant_valid, grant_id, ptr, slice_cnt);
endinterface

// File: rtl/rr_ring_arbiter.sv
// rr_ring_arbiter: round-robin arbiter with a one-hot rotating pointer and a per-grant time slice
module rr_ring_arbiter #(
    parameter int NREQ    = 4,
    parameter int QUANTUM = 8,
    parameter int IDW     = $clog2(NREQ),
    parameter int QW      = (QUANTUM > 1) ? $clog2(QUANTUM) : 1
) (
    input  logic              clk,
    input  logic              reset,
    rr_ring_arbiter_if.slave  bus
);
    typedef enum logic {IDLE, GRANT} state_t;

    state_t          r_state;
    logic [NREQ-1:0] r_grant;
    logic [IDW-1:0]  r_grant_id;
    logic [NREQ-1:0] r_ptr;
    logic [QW-1:0]   r_slice;

    logic [IDW-1:0]  w_ptr_id;
    logic [IDW-1:0]  w_idx;
    logic [IDW-1:0]  w_win_id;
    logic            w_found;
    logic [NREQ-1:0] w_win_oh;
    logic            w_release;

    // binary index of the pointer bit, the scan start position
    always_comb begin
        w_ptr_id = '0;
        for (int i = 0; i < NREQ; i++)
            if (r_ptr[i]) w_ptr_id = IDW'(i);
    end

    // first active request scanning upward from the pointer with wrap-around
    always_comb begin
        w_found  = 1'b0;
        w_win_id = '0;
        w_idx    = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_idx = IDW'((int'(w_ptr_id) + k) % NREQ);
            if (!w_found && bus.req[w_idx]) begin
                w_found  = 1'b1;
                w_win_id = w_idx;
            end
        end
    end

    assign w_win_oh  = NREQ'(1) << w_win_id;
    assign w_release = !bus.req[r_grant_id] || (r_slice == QW'(QUANTUM - 1));

    // arbitration FSM: grant the winner, hold it until it drops or its slice expires
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_grant    <= '0;
            r_grant_id <= '0;
            r_slice    <= '0;
            r_ptr      <= NREQ'(1);
        end else begin
            case (r_state)
                IDLE: if (w_found) begin
                    r_grant    <= w_win_oh;
                    r_grant_id <= w_win_id;
                    r_slice    <= '0;
                    r_state    <= GRANT;
                end
                GRANT: if (w_release) begin
                    r_grant    <= '0;
                    r_grant_id <= '0;
                    r_slice    <= '0;
                    r_ptr      <= {r_grant[NREQ-2:0], r_grant[NREQ-1]};
                    r_state    <= IDLE;
                end else begin
                    r_slice    <= r_slice + 1'b1;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.grant       = r_grant;
    assign bus.grant_valid = |r_grant;
    assign bus.grant_id    = r_grant_id;
    assign bus.ptr         = r_ptr;
    assign bus.slice_cnt   = r_slice;
endmodule
